// File: rtl/fifo_stream_out.sv
// Read-side adapter for the synchronous fifo: issues rd_en, absorbs the
// one-cycle read latency and presents words on a valid/ready stream through
// a two-entry skid buffer (head = output word, tail = overflow slot).
module fifo_stream_out #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [1:0]       buf_level
);

  logic [1:0]       count_q, count_d;
  logic             pending_q;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  logic       pop;
  logic [1:0] after_pop;
  logic [2:0] occ;
  logic [2:0] lim;

  assign pop       = (count_q != 2'd0) && m_ready;
  assign after_pop = count_q - {1'b0, pop};

  // Slots already committed (held + in flight) must stay below the room
  // available this cycle; a pop frees a slot in the same cycle, which is
  // what lets the read issue combinationally from m_ready at full rate.
  assign occ        = {1'b0, count_q} + {2'b00, pending_q};
  assign lim        = 3'd2 + {2'b00, pop};
  assign fifo_rd_en = n_reset && !fifo_empty && (occ < lim);

  assign m_valid   = (count_q != 2'd0);
  assign m_data    = head_q;
  assign buf_level = count_q;

  // Next-state of the skid buffer: pop shifts tail->head, an arriving word
  // lands in the first free slot after the pop.
  always_comb begin
    count_d = after_pop + {1'b0, pending_q};
    head_d  = head_q;
    tail_d  = tail_q;
    if (pop && (count_q == 2'd2))
      head_d = tail_q;
    if (pending_q) begin
      if (after_pop == 2'd0)
        head_d = fifo_data;
      else
        tail_d = fifo_data;
    end
  end

  // State registers with synchronous active-low reset; a reset drops any
  // in-flight and buffered words.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      count_q   <= 2'd0;
      pending_q <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      count_q   <= count_d;
      pending_q <= fifo_rd_en;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

endmodule
